// File: rtl/bin_to_bcd_serial.sv
// Serial double-dabble: unsigned binary to packed 8421 BCD, one bit per clock.
// Latency: BIN_W cycles busy, then one cycle done. Backpressure: enb=0 stalls; start ignored while busy.
// Result digits are always 0..9 and stay on bcd_out until the next done or reset.
module bin_to_bcd_serial #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enb,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam longint unsigned MAX_BIN = (64'd1 << BIN_W) - 64'd1;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;

    generate
        if (BIN_W < 1 || BIN_W > 16) begin : g_bad_bin_w
            $error("bin_to_bcd_serial: BIN_W must be in 1..16");
        end
        if (pow10(DIGITS) <= MAX_BIN) begin : g_bad_digits
            $error("bin_to_bcd_serial: DIGITS too small for BIN_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   sh_q, sh_d;
    logic [BCD_W-1:0]   scr_q, scr_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               busy_q, done_q;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   stepped;
    logic               accept;

    always_comb begin
        adj = scr_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (scr_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
        end
        stepped = {adj[BCD_W-2:0], sh_q[BIN_W-1]};
    end

    assign accept = enb && start && (state_q != SHIFT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        scr_d   = scr_q;
        bcd_d   = bcd_q;
        case (state_q)
            IDLE: ;
            SHIFT: begin
                if (enb) begin
                    scr_d = stepped;
                    sh_d  = sh_q << 1;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                        bcd_d   = stepped;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A start in the DONE cycle chains straight into the next conversion.
        if (accept) begin
            state_d = SHIFT;
            sh_d    = bin_in;
            scr_d   = '0;
            cnt_d   = CNT_W'(BIN_W);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            scr_q   <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            scr_q   <= scr_d;
            bcd_q   <= bcd_d;
            busy_q  <= (state_d == SHIFT);
            done_q  <= (state_d == DONE);
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Bench for bin_to_bcd_serial: randomized and directed conversions, scoreboard-checked
// against a decimal-arithmetic reference; latency, pause, chaining, ignored start and reset.
module tb_bin_to_bcd_serial;
    localparam int BIN_W  = 8;
    localparam int DIGITS = 3;

    logic                 clk = 1'b0;
    logic                 rst, enb, start;
    logic [BIN_W-1:0]     bin_in;
    logic                 busy, done;
    logic [4*DIGITS-1:0]  bcd_out;

    int checks = 0;
    int passed = 0;
    logic [4*DIGITS-1:0] exp_q[$];

    bin_to_bcd_serial #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst     (rst),
        .enb     (enb),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
    );

    always #5 clk = ~clk;

    function automatic logic [4*DIGITS-1:0] model(input int v);
        logic [4*DIGITS-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every done pulse must match the oldest outstanding conversion.
    always @(negedge clk) begin : mon
        logic [4*DIGITS-1:0] e;
        int bad;
        if (!rst && done) begin
            chk("done_busy_exclusive", int'(busy), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("bcd_out", int'(bcd_out), int'(e));
                bad = 0;
                for (int k = 0; k < DIGITS; k++) if (bcd_out[4*k +: 4] > 4'd9) bad++;
                chk("digit_range", bad, 0);
            end
        end
    end

    task automatic issue(input int v);
        bin_in = BIN_W'(v);
        start  = 1'b1;
        exp_q.push_back(model(v));
        step();
        start  = 1'b0;
        bin_in = BIN_W'($urandom);
    endtask

    // Starts in cycle 1 after the accepting edge; returns with done visible in the current cycle.
    task automatic wait_done(input int exp_cyc, input int pause_at, input int pause_len,
                             input int poke_at, input string name);
        int cyc;
        int busy_cnt;
        cyc = 1;
        busy_cnt = 0;
        while (!done && cyc < 100) begin
            if (busy) busy_cnt++;
            if (cyc == pause_at) enb = 1'b0;
            if (cyc == pause_at + pause_len) enb = 1'b1;
            if (cyc == poke_at) begin
                start  = 1'b1;
                bin_in = 8'd13;
            end else begin
                start = 1'b0;
            end
            step();
            cyc++;
        end
        enb   = 1'b1;
        start = 1'b0;
        chk({name, "_latency"}, cyc, exp_cyc);
        chk({name, "_busy_cycles"}, busy_cnt, exp_cyc - 1);
    endtask

    initial begin
        int n;
        int v, p, l;
        rst = 1'b1; enb = 1'b1; start = 1'b0; bin_in = '0;
        repeat (3) step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_bcd", int'(bcd_out), 0);
        rst = 1'b0;
        step();

        issue(0);
        wait_done(BIN_W + 1, -1, 0, -1, "zero");
        step();

        issue(255);
        wait_done(BIN_W + 1, -1, 0, -1, "max");
        step();

        issue(99);
        wait_done(BIN_W + 1, -1, 0, -1, "first_b2b");
        issue(128);
        chk("b2b_no_idle", int'(busy), 1);
        wait_done(BIN_W + 1, -1, 0, -1, "second_b2b");
        step();

        issue(47);
        wait_done(BIN_W + 4, 3, 3, -1, "pause");
        step();

        enb = 1'b0; start = 1'b1; bin_in = 8'd55;
        repeat (3) begin
            step();
            chk("gated_busy", int'(busy), 0);
            chk("gated_done", int'(done), 0);
        end
        start = 1'b0; enb = 1'b1;
        step();
        chk("gated_still_idle", int'(busy), 0);

        issue(200);
        wait_done(BIN_W + 1, -1, 0, 3, "ignored_start");
        step();
        n = 0;
        repeat (15) begin
            if (done) n++;
            step();
        end
        chk("no_extra_done", n, 0);

        issue(173);
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_bcd", int'(bcd_out), 0);
        rst = 1'b0;
        exp_q.delete();
        n = 0;
        repeat (12) begin
            if (done) n++;
            step();
        end
        chk("midrst_no_done", n, 0);
        issue(173);
        wait_done(BIN_W + 1, -1, 0, -1, "after_rst");
        step();

        for (int i = 0; i < 25; i++) begin
            v = $urandom_range(0, 255);
            issue(v);
            if ($urandom_range(0, 1) == 1) begin
                wait_done(BIN_W + 1, -1, 0, -1, "rand");
            end else begin
                p = $urandom_range(1, 6);
                l = $urandom_range(1, 3);
                wait_done(BIN_W + 1 + l, p, l, -1, "rand_pause");
            end
            if ($urandom_range(0, 1) == 1) step();
        end

        repeat (3) step();
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/bin_to_bcd_serial.md
Name: bin_to_bcd_serial

Overview:
Iterative shift-and-add-3 (double-dabble) converter from unsigned binary to packed 8421 BCD digits. It is the upstream stage of the 8421-to-2421 code converter. Each 4-bit digit of bcd_out feeds one converter instance directly, so every digit produced is guaranteed to be in the range 0..9. The block processes one binary bit per clock and uses a start/busy/done handshake.

Parameters:
BIN_W, 8, width of the binary input in bits (legal range 1..16).
DIGITS, 3, number of BCD output digits. Elaboration must fail if 10^DIGITS <= 2^BIN_W - 1.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
enb  input  1  global enable; low pauses the conversion and blocks new starts
start  input  1  request a conversion of bin_in; sampled on clk
bin_in  input  BIN_W  unsigned binary operand; sampled only when start is accepted
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse; bcd_out is updated in the same cycle
bcd_out  output  4*DIGITS  packed BCD result; digit k occupies bits [4k+3:4k]; digit 0 is the units digit

Behaviour:
- Reset (rst sampled high): state=IDLE, busy=0, done=0, bcd_out=0, internal shift and digit registers cleared. Reset overrides all other inputs. Reset mid-conversion aborts the conversion; bcd_out returns to 0 and no done pulse is issued.
- States: IDLE, SHIFT, DONE.
- Start acceptance:
  - Accepted when the state is IDLE or DONE, enb=1 and start=1.
  - On acceptance: capture bin_in into the shift register, clear the digit scratch, set the bit counter to BIN_W, go to SHIFT.
  - start while in SHIFT is ignored. The operand is not queued.
- SHIFT step (only when enb=1):
  - For every scratch digit >= 5, add 3 (4-bit add, no carry out).
  - Then shift {scratch, shift_reg} left by 1, bringing in the shift_reg MSB.
  - Decrement the counter.
  - After the step with counter==1, go to DONE.
- Pause: enb=0 while in SHIFT freezes the state, counter and scratch. busy stays 1.
- DONE: lasts exactly one cycle.
  - On entry, bcd_out is loaded from the scratch.
  - done=1 and busy=0 during this cycle.
  - If no start is accepted, go to IDLE. An accepted start goes straight to SHIFT (back-to-back throughput of one conversion per BIN_W+1 cycles).
- Timing: busy is registered.
  - If start is accepted at edge T, busy=1 from T+1 through T+BIN_W.
  - done=1 in cycle T+BIN_W+1, with bcd_out valid from that cycle.
  - Each cycle of enb=0 during SHIFT adds one cycle of latency.
- bcd_out holds its value until the next DONE or reset. It is unaffected by enb and by bin_in changes.
- Every result digit is <= 9. Unused high digits are 0.
- done is never high while busy is high. busy and done are both 0 in IDLE.

Test Plan:
- Reset, then bin_in=0 with a start pulse, enb=1 -> busy high for 8 cycles; done at start+9 with bcd_out=12'h000.
- bin_in=255 -> bcd_out=12'h255 (0010_0101_0101) on done; all digits <= 9 and legal for the 2421 stage.
- bin_in=99, then start held high in the DONE cycle with bin_in=128 -> first done shows 12'h099; second conversion starts without an idle cycle; second done 9 cycles later shows 12'h128.
- bin_in=47 with enb dropped for 3 cycles mid-SHIFT -> busy stays high throughout; done at start+12; bcd_out=12'h047. Also, start asserted with enb=0 in IDLE -> no busy, no done.
- Start 200, then start pulsed with bin_in=13 during SHIFT -> second start ignored; done shows 12'h200; no second done follows.
- Start 173, rst asserted at start+4 -> next cycle busy=0, done=0, bcd_out=0; no done pulse afterwards. A new start of 173 completes normally with 12'h173.
